// File: rtl/cgra_net_iface.sv
// PE <-> router local-port network interface: TX flit packing FIFO, RX unpacking FIFO,
// sticky misroute flag. Optional saturating flit counters under CGRA_NI_STATS_EN.
module cgra_net_iface #(
   parameter int DATA_WIDTH    = 32,
   parameter int COORD_WIDTH   = 4,
   parameter int PAYLOAD_WIDTH = 16,
   parameter int X_COORD       = 0,
   parameter int Y_COORD       = 0,
   parameter int TX_DEPTH      = 4,
   parameter int RX_DEPTH      = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PAYLOAD_WIDTH-1:0] pe_tx_payload,
   input  logic [COORD_WIDTH-1:0]   pe_tx_dx,
   input  logic [COORD_WIDTH-1:0]   pe_tx_dy,
   input  logic [7:0]               pe_tx_tag,
   input  logic                     pe_tx_valid,
   output logic                     pe_tx_ready,
   output logic [DATA_WIDTH-1:0]    net_data_out,
   output logic                     net_valid_out,
   input  logic                     net_ready_in,
   input  logic [DATA_WIDTH-1:0]    net_data_in,
   input  logic                     net_valid_in,
   output logic                     net_ready_out,
   output logic [PAYLOAD_WIDTH-1:0] pe_rx_payload,
   output logic [7:0]               pe_rx_tag,
   output logic                     pe_rx_valid,
   input  logic                     pe_rx_ready,
   output logic                     err_misroute,
   output logic [15:0]              tx_flit_cnt,
   output logic [15:0]              rx_flit_cnt
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int RXW   = 8 + PAYLOAD_WIDTH;
   localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
   localparam logic [COORD_WIDTH-1:0] MY_X = COORD_WIDTH'(X_COORD);
   localparam logic [COORD_WIDTH-1:0] MY_Y = COORD_WIDTH'(Y_COORD);

   // Handshakes: a transfer happens on a rising edge where valid && ready. Valid never
   // depends on ready, and every ready/valid output here comes from registered occupancy.

   logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]      tx_wr_ptr, tx_rd_ptr;
   logic [TX_AW:0]        tx_cnt;
   logic                  tx_empty, tx_full, tx_push, tx_pop;

   assign tx_empty      = (tx_cnt == '0);
   assign tx_full       = (tx_cnt == TX_FULL_CNT);
   assign pe_tx_ready   = !tx_full;
   assign net_valid_out = !tx_empty;
   assign net_data_out  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
   assign tx_push       = pe_tx_valid && pe_tx_ready;
   assign tx_pop        = net_valid_out && net_ready_in;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= {pe_tx_dx, pe_tx_dy, pe_tx_tag, pe_tx_payload};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_cnt    <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
         else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
      end
   end

   // Only tag and payload are kept; the address is consumed by the misroute check.
   logic [RXW-1:0]   rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_AW:0]   rx_cnt;
   logic             rx_empty, rx_full, rx_push, rx_pop;
   logic [RXW-1:0]   rx_head;

   assign rx_empty      = (rx_cnt == '0);
   assign rx_full       = (rx_cnt == RX_FULL_CNT);
   assign net_ready_out = !rx_full;
   assign pe_rx_valid   = !rx_empty;
   assign rx_head       = rx_empty ? '0 : rx_mem[rx_rd_ptr];
   assign pe_rx_payload = rx_head[PAYLOAD_WIDTH-1:0];
   assign pe_rx_tag     = rx_head[RXW-1:PAYLOAD_WIDTH];
   assign rx_push       = net_valid_in && net_ready_out;
   assign rx_pop        = pe_rx_valid && pe_rx_ready;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= net_data_in[RXW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wr_ptr    <= '0;
         rx_rd_ptr    <= '0;
         rx_cnt       <= '0;
         err_misroute <= 1'b0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
         else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
         if (rx_push && ((net_data_in[DATA_WIDTH-1 -: COORD_WIDTH] != MY_X) ||
                         (net_data_in[DATA_WIDTH-COORD_WIDTH-1 -: COORD_WIDTH] != MY_Y)))
            err_misroute <= 1'b1;
      end
   end

`ifdef CGRA_NI_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_flit_cnt <= '0;
         rx_flit_cnt <= '0;
      end else begin
         if (tx_pop && (tx_flit_cnt != 16'hFFFF))  tx_flit_cnt <= tx_flit_cnt + 1'b1;
         if (rx_push && (rx_flit_cnt != 16'hFFFF)) rx_flit_cnt <= rx_flit_cnt + 1'b1;
      end
   end
`else
   assign tx_flit_cnt = '0;
   assign rx_flit_cnt = '0;
`endif

endmodule
